multdiv_issue_ctrl: RTL and testbench
=====================================

MULTDIV_ISSUE_CTRL -- requirements
Module: multdiv_issue_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 48: maximum number of BUSY cycles before the block abandons an operation.
REQ-002 Parameter RSTATUS_REG, default 30: destination register for exception status.
REQ-003 Port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port issue_valid, input, 1: execute stage holds a mult/div instruction.
REQ-006 Port issue_is_div, input, 1: 1 = div, 0 = mult.
REQ-007 Ports issue_opA / issue_opB, input, 32 each: source operands.
REQ-008 Port issue_rd, input, 5: destination register.
REQ-009 Port flush, input, 1: abort the in-flight operation.
REQ-010 Port stall, output, 1: freeze upstream pipeline.
REQ-011 Ports md_ctrl_MULT / md_ctrl_DIV, output, 1 each: start pulses to the multiplier/divider.
REQ-012 Ports md_operandA / md_operandB, output, 32 each: latched operands.
REQ-013 Ports md_result, input, 32; md_exception, input, 1; md_resultRDY, input, 1: multdiv outputs.
REQ-014 Ports wb_valid, output, 1; wb_rd, output, 5; wb_data, output, 32: writeback request.
REQ-015 Port busy_count, output, 6: cycles spent in the current BUSY episode.

Function
REQ-016 FSM states SHALL be IDLE, START, BUSY, DONE.
REQ-017 IDLE with issue_valid=1 and flush=0 SHALL latch opA, opB, rd and is_div, then go to START.
- stall=1 combinationally in that same cycle.
REQ-018 START SHALL last exactly one cycle.
- md_ctrl_DIV=is_div and md_ctrl_MULT=~is_div, both Moore outputs; never both high.
- Next state is BUSY.
REQ-019 md_operandA/B SHALL hold the latched values from START through DONE.
REQ-020 md_resultRDY SHALL be ignored in START; only BUSY samples it.
REQ-021 BUSY with md_resultRDY=1 SHALL capture the result and go to DONE.
- Normal: wb_data=md_result, wb_rd=latched rd.
- md_exception=1: wb_rd=RSTATUS_REG, wb_data=4 (mult) or 5 (div).
REQ-022 BUSY timeout:
- busy_count SHALL increment every BUSY cycle, saturating at 63.
- busy_count SHALL clear on entry to START.
- If busy_count reaches TIMEOUT_CYCLES without md_resultRDY, go to DONE with the exception writeback of REQ-021.
REQ-023 DONE SHALL last one cycle with wb_valid=1 and stall=0, then return to IDLE.
- issue_valid SHALL be ignored in DONE, so the retiring instruction is not re-issued.
REQ-024 stall SHALL be 1 in START and BUSY, in IDLE only per REQ-017, and 0 in DONE.
REQ-025 flush=1 in START, BUSY or DONE SHALL force IDLE at the next edge.
- wb_valid SHALL be forced to 0 in that cycle; stall=0 from the next cycle.
- A START pulse in the flush cycle still occurs; its result is discarded.
REQ-026 flush and md_resultRDY together in BUSY: flush SHALL win.
REQ-027 wb_valid SHALL be 0 in all states except DONE.

Reset
REQ-028 reset_n=0 SHALL immediately force IDLE, including mid-operation.
- All outputs 0: stall, md_ctrl_*, md_operand*, wb_*, busy_count.
REQ-029 The first issue after reset_n deasserts SHALL be accepted in the next IDLE cycle.

Structure
REQ-030 Shared package multdiv_pkg SHALL hold:
- the state enumeration;
- RSTATUS_REG default (30);
- EXC_MULT=4 and EXC_DIV=5;
- TIMEOUT_CYCLES default (48).
REQ-031 One sub-module, md_busy_counter (6-bit saturating counter with clear and enable), SHALL implement busy_count; all else is flat.

Verification
REQ-032 Mult 6*7, rd=5, model RDY after 17 cycles.
- Expect one ctrl_MULT pulse, then wb_valid=1 with wb_rd=5, wb_data=42.
- stall high for exactly 1+1+17 cycles (IDLE accept + START + BUSY).
REQ-033 Div 100 / -7, rd=9.
- Expect wb_data=0xFFFFFFF2 (-14), wb_rd=9; ctrl_MULT never asserted.
REQ-034 Div 5/0 with the model asserting md_exception -> wb_rd=30, wb_data=5.
- Mult 0x40000000*4 with md_exception -> wb_rd=30, wb_data=4.
REQ-035 Flush 8 cycles into BUSY, then RDY two cycles later.
- Expect no wb_valid, stall=0 next cycle.
- A following issue is accepted normally.
REQ-036 Model never asserts RDY.
- Expect wb_valid exactly 48 BUSY cycles after START with wb_rd=30, wb_data=4/5.
- busy_count=48 at that edge.
REQ-037 reset_n low mid-BUSY.
- Expect all outputs 0 asynchronously and no wb_valid after release.
- Back-to-back issues (issue_valid held through DONE) -> exactly one writeback per instruction.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the mult/div issue controller.
// Exception status codes are written to the status register when an operation faults or times out.
package multdiv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      BUSY  = 2'd2,
      DONE  = 2'd3
   } md_state_e;

   localparam int          RSTATUS_REG_DEF    = 30;
   localparam int          TIMEOUT_CYCLES_DEF = 48;
   localparam logic [31:0] EXC_MULT           = 32'd4;
   localparam logic [31:0] EXC_DIV            = 32'd5;

   function automatic logic [31:0] exc_code(input logic is_div);
      return is_div ? EXC_DIV : EXC_MULT;
   endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Saturating 6-bit cycle counter with synchronous clear and count enable.
module md_busy_counter (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       clr,
   input  logic       en,
   output logic [5:0] count
);

   logic [5:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && (count_q != 6'h3f)) begin
         count_d = count_q + 6'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Issue controller between the execute stage and the multiplier/divider: latches operands,
// pulses the start strobe, waits for the result (with timeout) and raises a writeback request.
//
//   state | meaning
//   IDLE  | waiting for an issue; accepting one stalls upstream in the same cycle
//   START | one-cycle start pulse to the multiplier or divider
//   BUSY  | waiting for md_resultRDY or the timeout
//   DONE  | one-cycle writeback, upstream released
module multdiv_issue_ctrl
   import multdiv_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int RSTATUS_REG    = RSTATUS_REG_DEF
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        issue_valid,
   input  logic        issue_is_div,
   input  logic [31:0] issue_opA,
   input  logic [31:0] issue_opB,
   input  logic [4:0]  issue_rd,
   input  logic        flush,
   output logic        stall,
   output logic        md_ctrl_MULT,
   output logic        md_ctrl_DIV,
   output logic [31:0] md_operandA,
   output logic [31:0] md_operandB,
   input  logic [31:0] md_result,
   input  logic        md_exception,
   input  logic        md_resultRDY,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic [5:0]  busy_count
);

   md_state_e   state_q, state_d;
   logic [31:0] opa_q, opa_d;
   logic [31:0] opb_q, opb_d;
   logic [4:0]  rd_q, rd_d;
   logic        is_div_q, is_div_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [31:0] wb_data_q, wb_data_d;

   logic        stall_c;
   logic        cnt_clr;
   logic        cnt_en;
   logic [5:0]  busy_count_w;
   logic [6:0]  busy_inc;
   logic        timeout;

   md_busy_counter u_busy_counter (
      .clock   (clock),
      .reset_n (reset_n),
      .clr     (cnt_clr),
      .en      (cnt_en),
      .count   (busy_count_w)
   );

   // Timeout fires in the BUSY cycle whose increment brings the count to TIMEOUT_CYCLES.
   assign busy_inc = {1'b0, busy_count_w} + 7'd1;
   assign timeout  = (int'(busy_inc) >= TIMEOUT_CYCLES);

   always_comb begin
      state_d      = state_q;
      opa_d        = opa_q;
      opb_d        = opb_q;
      rd_d         = rd_q;
      is_div_d     = is_div_q;
      wb_rd_d      = wb_rd_q;
      wb_data_d    = wb_data_q;
      stall_c      = 1'b0;
      md_ctrl_MULT = 1'b0;
      md_ctrl_DIV  = 1'b0;
      wb_valid     = 1'b0;
      cnt_clr      = 1'b0;
      cnt_en       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (issue_valid && !flush) begin
               stall_c  = 1'b1;
               opa_d    = issue_opA;
               opb_d    = issue_opB;
               rd_d     = issue_rd;
               is_div_d = issue_is_div;
               cnt_clr  = 1'b1;
               state_d  = START;
            end
         end
         START: begin
            stall_c      = 1'b1;
            md_ctrl_DIV  = is_div_q;
            md_ctrl_MULT = !is_div_q;
            state_d      = flush ? IDLE : BUSY;
         end
         BUSY: begin
            stall_c = 1'b1;
            cnt_en  = 1'b1;
            if (flush) begin
               state_d = IDLE;
            end else if (md_resultRDY) begin
               if (md_exception) begin
                  wb_rd_d   = 5'(RSTATUS_REG);
                  wb_data_d = exc_code(is_div_q);
               end else begin
                  wb_rd_d   = rd_q;
                  wb_data_d = md_result;
               end
               state_d = DONE;
            end else if (timeout) begin
               wb_rd_d   = 5'(RSTATUS_REG);
               wb_data_d = exc_code(is_div_q);
               state_d   = DONE;
            end
         end
         DONE: begin
            wb_valid = !flush;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         opa_q     <= '0;
         opb_q     <= '0;
         rd_q      <= '0;
         is_div_q  <= 1'b0;
         wb_rd_q   <= '0;
         wb_data_q <= '0;
      end else begin
         state_q   <= state_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         rd_q      <= rd_d;
         is_div_q  <= is_div_d;
         wb_rd_q   <= wb_rd_d;
         wb_data_q <= wb_data_d;
      end
   end

   // The IDLE accept stall is combinational from issue_valid, so hold it low while reset is applied.
   assign stall       = stall_c & reset_n;
   assign md_operandA = opa_q;
   assign md_operandB = opb_q;
   assign wb_rd       = wb_rd_q;
   assign wb_data     = wb_data_q;
   assign busy_count  = busy_count_w;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Self-checking bench for multdiv_issue_ctrl: directed vector table, hand sequences for reset
// and back-to-back issue, and randomized transactions against a transaction-level model.
module tb_multdiv_issue_ctrl;

   localparam int TO = 48;
   localparam int RS = 30;

   logic        clock;
   logic        reset_n;
   logic        issue_valid;
   logic        issue_is_div;
   logic [31:0] issue_opA;
   logic [31:0] issue_opB;
   logic [4:0]  issue_rd;
   logic        flush;
   logic        stall;
   logic        md_ctrl_MULT;
   logic        md_ctrl_DIV;
   logic [31:0] md_operandA;
   logic [31:0] md_operandB;
   logic [31:0] md_result;
   logic        md_exception;
   logic        md_resultRDY;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [5:0]  busy_count;

   int errors = 0;
   int checks = 0;

   multdiv_issue_ctrl dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .issue_valid  (issue_valid),
      .issue_is_div (issue_is_div),
      .issue_opA    (issue_opA),
      .issue_opB    (issue_opB),
      .issue_rd     (issue_rd),
      .flush        (flush),
      .stall        (stall),
      .md_ctrl_MULT (md_ctrl_MULT),
      .md_ctrl_DIV  (md_ctrl_DIV),
      .md_operandA  (md_operandA),
      .md_operandB  (md_operandB),
      .md_result    (md_result),
      .md_exception (md_exception),
      .md_resultRDY (md_resultRDY),
      .wb_valid     (wb_valid),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .busy_count   (busy_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        dv;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      int          lat;      // BUSY cycle carrying RDY, 0 = never
      logic        exc;
      int          flush_k;  // -1 none, 0 = START, k = k-th BUSY cycle, nb+1 = DONE
      logic [4:0]  x_rd;
      logic [31:0] x_data;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Behaviour of the arithmetic unit itself (what it would return on RDY).
   function automatic logic [31:0] md_calc(input logic dv, input logic [31:0] a, input logic [31:0] b);
      if (!dv) return a * b;
      if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hffff_ffff)) return 32'd0;
      return $signed(a) / $signed(b);
   endfunction

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         issue_valid  = 1'b0;
         flush        = 1'b0;
         md_resultRDY = 1'b0;
         @(negedge clock);
         chk("idle", {stall, wb_valid, md_ctrl_MULT, md_ctrl_DIV}, 4'b0000);
         @(posedge clock); #1;
      end
   endtask

   // One transaction, starting in an IDLE cycle; returns just after the last checked edge.
   task automatic run_op(input int id, input logic dv, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int lat, input logic exc, input int flush_k,
                         input logic rdy_start, input logic hold,
                         input logic [4:0] x_rd, input logic [31:0] x_data);
      int   nb, fc, last;
      logic hold_eff;
      logic es, ew, em, ed;
      nb       = (lat > 0 && lat <= TO) ? lat : TO;
      fc       = (flush_k >= 0 && flush_k <= nb + 1) ? 1 + flush_k : -1;
      hold_eff = hold && (fc < 0);
      last     = (fc >= 0) ? fc + 3 : 2 + nb;
      for (int c = 0; c <= last; c++) begin
         if (c == 0) begin
            issue_valid  = 1'b1;
            issue_is_div = dv;
            issue_opA    = a;
            issue_opB    = b;
            issue_rd     = rd;
         end else begin
            issue_valid  = hold_eff && (c <= 2 + nb);
            issue_is_div = 1'($urandom);
            issue_opA    = $urandom;
            issue_opB    = $urandom;
            issue_rd     = 5'($urandom);
         end
         flush        = (c == fc);
         md_resultRDY = (c == 1) ? rdy_start : (c >= 2 && c - 1 == lat);
         md_exception = md_resultRDY & exc;
         md_result    = md_resultRDY ? md_calc(dv, a, b) : $urandom;
         @(negedge clock);
         if (fc >= 0 && c > fc) begin
            es = 1'b0; ew = 1'b0; em = 1'b0; ed = 1'b0;
         end else begin
            es = (c <= 1 + nb);
            ew = (c == 2 + nb) && (c != fc);
            em = (c == 1) && !dv;
            ed = (c == 1) && dv;
         end
         chk($sformatf("op%0d c%0d ctl", id, c), {stall, wb_valid, md_ctrl_MULT, md_ctrl_DIV}, {es, ew, em, ed});
         if (c >= 1 && (fc < 0 || c <= fc))
            chk($sformatf("op%0d c%0d operands", id, c), {md_operandA, md_operandB}, {a, b});
         if (c >= 1 && c <= 1 + nb && (fc < 0 || c <= fc))
            chk($sformatf("op%0d c%0d busy_count", id, c), 64'(busy_count), 64'((c >= 2) ? c - 2 : 0));
         if (ew) begin
            chk($sformatf("op%0d wb", id), {wb_rd, wb_data}, {x_rd, x_data});
            chk($sformatf("op%0d wb busy_count", id), 64'(busy_count), 64'(nb));
         end
         @(posedge clock); #1;
      end
      issue_valid  = hold_eff;
      flush        = 1'b0;
      md_resultRDY = 1'b0;
      md_exception = 1'b0;
   endtask

   initial begin
      logic        dv, exc, rs, hold;
      logic [31:0] a, b, xd;
      logic [4:0]  rd, xr;
      int          lat, fk, nb, sel;

      vecs[0]  = '{1'b0, 32'd6,          32'd7,          5'd5, 17, 1'b0, -1, 5'd5,  32'd42};
      vecs[1]  = '{1'b1, 32'd100,        32'hffff_fff9,  5'd9, 20, 1'b0, -1, 5'd9,  32'hffff_fff2};
      vecs[2]  = '{1'b1, 32'd5,          32'd0,          5'd3, 10, 1'b1, -1, 5'd30, 32'd5};
      vecs[3]  = '{1'b0, 32'h4000_0000,  32'd4,          5'd7, 4,  1'b1, -1, 5'd30, 32'd4};
      vecs[4]  = '{1'b0, 32'd3,          32'd3,          5'd1, 0,  1'b0, -1, 5'd30, 32'd4};
      vecs[5]  = '{1'b1, 32'd9,          32'd3,          5'd2, 0,  1'b0, -1, 5'd30, 32'd5};
      vecs[6]  = '{1'b0, 32'd2,          32'd2,          5'd4, 10, 1'b0, 8,  5'd0,  32'd0};
      vecs[7]  = '{1'b0, 32'd11,         32'd13,         5'd6, 1,  1'b0, -1, 5'd6,  32'd143};
      vecs[8]  = '{1'b1, 32'd7,          32'd2,          5'd8, 48, 1'b0, -1, 5'd8,  32'd3};
      vecs[9]  = '{1'b1, 32'd7,          32'd2,          5'd8, 49, 1'b0, -1, 5'd30, 32'd5};
      vecs[10] = '{1'b0, 32'd1,          32'd1,          5'd3, 3,  1'b0, 0,  5'd0,  32'd0};
      vecs[11] = '{1'b1, 32'd20,         32'd4,          5'd3, 5,  1'b0, 6,  5'd0,  32'd0};

      reset_n      = 1'b1;
      issue_valid  = 1'b0;
      issue_is_div = 1'b0;
      issue_opA    = '0;
      issue_opB    = '0;
      issue_rd     = '0;
      flush        = 1'b0;
      md_result    = '0;
      md_exception = 1'b0;
      md_resultRDY = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk("reset ctl", {stall, md_ctrl_MULT, md_ctrl_DIV, wb_valid, wb_rd, busy_count}, '0);
      chk("reset operands", {md_operandA, md_operandB}, '0);
      chk("reset wb_data", 64'(wb_data), '0);
      repeat (2) @(posedge clock);
      #3 reset_n = 1'b1;
      @(posedge clock); #1;

      for (int i = 0; i < 12; i++)
         run_op(i, vecs[i].dv, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].lat, vecs[i].exc,
                vecs[i].flush_k, 1'(i % 2), 1'b0, vecs[i].x_rd, vecs[i].x_data);
      idle_cycles(2);

      // Reset asserted asynchronously in the middle of BUSY.
      issue_valid  = 1'b1;
      issue_is_div = 1'b1;
      issue_opA    = 32'd1000;
      issue_opB    = 32'd10;
      issue_rd     = 5'd12;
      @(negedge clock);
      chk("mid accept stall", 64'(stall), 64'd1);
      @(posedge clock); #1;
      issue_valid = 1'b0;
      repeat (6) @(posedge clock);
      #3;
      chk("mid busy_count", 64'(busy_count), 64'd5);
      chk("mid operands", {md_operandA, md_operandB}, {32'd1000, 32'd10});
      reset_n = 1'b0;
      #1;
      chk("mid reset ctl", {stall, md_ctrl_MULT, md_ctrl_DIV, wb_valid, wb_rd, busy_count}, '0);
      chk("mid reset operands", {md_operandA, md_operandB}, '0);
      chk("mid reset wb_data", 64'(wb_data), '0);
      repeat (2) @(posedge clock);
      #3 reset_n = 1'b1;
      @(posedge clock); #1;
      for (int i = 0; i < 3; i++) begin
         md_resultRDY = 1'b1;
         md_result    = 32'd77;
         @(negedge clock);
         chk("post reset quiet", {stall, wb_valid}, 2'b00);
         @(posedge clock); #1;
      end
      md_resultRDY = 1'b0;
      run_op(100, 1'b0, 32'd9, 32'd9, 5'd17, 3, 1'b0, -1, 1'b0, 1'b0, 5'd17, 32'd81);

      // Back-to-back: issue_valid held through DONE.
      run_op(101, 1'b0, 32'd3, 32'd5, 5'd10, 2, 1'b0, -1, 1'b0, 1'b1, 5'd10, 32'd15);
      run_op(102, 1'b1, 32'd50, 32'd5, 5'd11, 4, 1'b0, -1, 1'b0, 1'b1, 5'd11, 32'd10);
      run_op(103, 1'b0, 32'd7, 32'd7, 5'd12, 1, 1'b0, -1, 1'b0, 1'b0, 5'd12, 32'd49);
      idle_cycles(1);

      for (int i = 0; i < 40; i++) begin
         dv  = 1'($urandom_range(0, 1));
         a   = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 1000);
         b   = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(1, 1000);
         if ($urandom_range(0, 9) == 0) b = 32'd0;
         rd  = 5'($urandom);
         sel = $urandom_range(0, 9);
         lat = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(46, 52) : $urandom_range(1, 25);
         exc = ($urandom_range(0, 7) == 0) ||
               (dv && (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hffff_ffff)));
         nb  = (lat > 0 && lat <= TO) ? lat : TO;
         fk  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, nb + 1) : -1;
         rs  = 1'($urandom_range(0, 1));
         hold = ($urandom_range(0, 3) == 0);
         if (exc || lat == 0 || lat > TO) begin
            xr = 5'(RS);
            xd = dv ? 32'd5 : 32'd4;
         end else begin
            xr = rd;
            xd = md_calc(dv, a, b);
         end
         run_op(200 + i, dv, a, b, rd, lat, exc, fk, rs, hold, xr, xd);
         if (!hold) idle_cycles($urandom_range(0, 2));
      end
      issue_valid = 1'b0;
      idle_cycles(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
